// File: rtl/prince_sbox_cms_ctrl.sv
// Nibble-serial sequencer feeding one shared pipelined CMS PRINCE S-box and writing results back in place.
// Optional inverse-S-box selection is enabled with `define PRINCE_SBOX_CTRL_INV_EN.
module prince_sbox_cms_ctrl #(
   parameter int SHARES  = 3,
   parameter int LATENCY = 2   // S-box pipeline depth, legal range 1..4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [64*SHARES-1:0]   in_data,
`ifdef PRINCE_SBOX_CTRL_INV_EN
   input  logic                   in_inv,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [64*SHARES-1:0]   out_data,
   output logic                   busy,
   output logic [4*SHARES-1:0]    sbox_in,
   output logic                   sbox_in_valid,
`ifdef PRINCE_SBOX_CTRL_INV_EN
   output logic                   sbox_inv,
`endif
   input  logic [4*SHARES-1:0]    sbox_out
);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [64*SHARES-1:0]   data_reg;
   logic [3:0]             feed_cnt_reg;
   logic [4:0]             cap_cnt_reg;
   logic [LATENCY-1:0]     vld_pipe_reg;
   logic                   accept;
   logic                   cap_en;

   assign accept = in_valid & in_ready;
   // The tracked valid bit lines up with the S-box result of the same nibble.
   assign cap_en = vld_pipe_reg[LATENCY-1];

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = FEED;
         FEED:    if (feed_cnt_reg == 4'd15) state_next = DRAIN;
         DRAIN:   if (cap_en && cap_cnt_reg == 5'd15) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign in_ready      = (state_reg == IDLE) & ~rst;
   assign busy          = (state_reg != IDLE);
   assign out_valid     = (state_reg == DONE);
   assign out_data      = data_reg;
   assign sbox_in_valid = (state_reg == FEED);

   // Read nibble feed_cnt of each share; the bus is zeroed when not feeding.
   for (genvar gi = 0; gi < SHARES; gi++) begin : g_feed
      assign sbox_in[4*gi +: 4] = sbox_in_valid ? data_reg[64*gi + 4*feed_cnt_reg +: 4] : 4'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         data_reg     <= '0;
         feed_cnt_reg <= 4'd0;
         cap_cnt_reg  <= 5'd0;
         vld_pipe_reg <= '0;
      end else begin
         state_reg       <= state_next;
         vld_pipe_reg[0] <= sbox_in_valid;
         for (int k = 1; k < LATENCY; k++) begin
            vld_pipe_reg[k] <= vld_pipe_reg[k-1];
         end
         if (accept) begin
            data_reg     <= in_data;
            feed_cnt_reg <= 4'd0;
            cap_cnt_reg  <= 5'd0;
         end else begin
            if (state_reg == FEED && feed_cnt_reg != 4'd15) begin
               feed_cnt_reg <= feed_cnt_reg + 4'd1;
            end
            // Write-back index always trails the read index, so in-place update is safe.
            if (cap_en) begin
               for (int s = 0; s < SHARES; s++) begin
                  data_reg[64*s + 4*cap_cnt_reg[3:0] +: 4] <= sbox_out[4*s +: 4];
               end
               cap_cnt_reg <= cap_cnt_reg + 5'd1;
            end
         end
      end
   end

`ifdef PRINCE_SBOX_CTRL_INV_EN
   logic inv_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inv_reg <= 1'b0;
      end else if (accept) begin
         inv_reg <= in_inv;
      end
   end

   assign sbox_inv = inv_reg & busy;
`endif

endmodule

// File: tb/tb_prince_sbox_cms_ctrl.sv
// Self-checking bench: three controllers (LATENCY 2, 1, 4) each driving a behavioural masked S-box pipeline.
// Inverse tests are included when PRINCE_SBOX_CTRL_INV_EN is defined.
module tb_prince_sbox_cms_ctrl;
   localparam int NI = 3;
   localparam int SH = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          in_valid      [NI];
   logic          in_ready      [NI];
   logic [191:0]  in_data       [NI];
   logic          out_valid     [NI];
   logic          out_ready     [NI];
   logic [191:0]  out_data      [NI];
   logic          busy          [NI];
   logic [11:0]   sbox_in       [NI];
   logic          sbox_in_valid [NI];
   logic [11:0]   sbox_out      [NI];
`ifdef PRINCE_SBOX_CTRL_INV_EN
   logic          in_inv        [NI];
   logic          sbox_inv      [NI];
`endif

   int checks = 0;
   int errors = 0;

   logic [3:0] sb [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                          4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
   endfunction

   function automatic logic [3:0] s_apply(input logic [3:0] x, input logic inv);
      logic [3:0] r;
      r = sb[x];
      if (inv) begin
         for (int v = 0; v < 16; v++) if (sb[v] == x) r = 4'(v);
      end
      return r;
   endfunction

   function automatic logic [63:0] ref_sub(input logic [63:0] p, input logic inv);
      logic [63:0] r;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = s_apply(p[4*i +: 4], inv);
      return r;
   endfunction

   function automatic logic [63:0] comb64(input logic [191:0] d);
      return d[63:0] ^ d[127:64] ^ d[191:128];
   endfunction

   function automatic logic [3:0] comb4(input logic [11:0] d);
      return d[3:0] ^ d[7:4] ^ d[11:8];
   endfunction

   // Re-masked S-box: only the XOR of output shares is meaningful.
   function automatic logic [11:0] model_sbox(input logic [11:0] x, input logic inv);
      logic [3:0] y, m1, m2;
      y  = s_apply(comb4(x), inv);
      m1 = 4'($urandom);
      m2 = 4'($urandom);
      return {m2, m1, y ^ m1 ^ m2};
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
      logic [11:0] pipe [L];
      logic        inv_w;
`ifdef PRINCE_SBOX_CTRL_INV_EN
      assign inv_w = sbox_inv[gi];
`else
      assign inv_w = 1'b0;
`endif
      always @(posedge clk) begin
         pipe[0] <= model_sbox(sbox_in[gi], inv_w);
         for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
      end
      assign sbox_out[gi] = pipe[L-1];

      prince_sbox_cms_ctrl #(.SHARES(SH), .LATENCY(L)) u_dut (
         .clk           (clk),
         .rst           (rst),
         .in_valid      (in_valid[gi]),
         .in_ready      (in_ready[gi]),
         .in_data       (in_data[gi]),
`ifdef PRINCE_SBOX_CTRL_INV_EN
         .in_inv        (in_inv[gi]),
`endif
         .out_valid     (out_valid[gi]),
         .out_ready     (out_ready[gi]),
         .out_data      (out_data[gi]),
         .busy          (busy[gi]),
         .sbox_in       (sbox_in[gi]),
         .sbox_in_valid (sbox_in_valid[gi]),
`ifdef PRINCE_SBOX_CTRL_INV_EN
         .sbox_inv      (sbox_inv[gi]),
`endif
         .sbox_out      (sbox_out[gi])
      );
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_outputs(input int k, input string tag);
      chk({tag, "_in_ready"},      64'(in_ready[k]), 64'd0);
      chk({tag, "_out_valid"},     64'(out_valid[k]), 64'd0);
      chk({tag, "_busy"},          64'(busy[k]), 64'd0);
      chk({tag, "_sbox_in_valid"}, 64'(sbox_in_valid[k]), 64'd0);
      chk({tag, "_sbox_in"},       64'(sbox_in[k]), 64'd0);
      chk({tag, "_out_data_nz"},   64'(|out_data[k]), 64'd0);
`ifdef PRINCE_SBOX_CTRL_INV_EN
      chk({tag, "_sbox_inv"},      64'(sbox_inv[k]), 64'd0);
`endif
   endtask

   // Runs one job on instance k from a negedge; returns recombined result and accept cycle.
   task automatic run_job(input int k, input logic [63:0] plain, input logic inv, input int hold,
                          output logic [63:0] res, output int t0);
      logic [63:0]  s1, s2, tmp;
      logic [191:0] snap;
      int           lat, first_v, last_v, cnt_v, rel, g, L;
      bit           done;
      L  = lat_of(k);
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      g  = 0;
      while (!in_ready[k] && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk("accept_in_ready", 64'(in_ready[k]), 64'd1);
      t0          = cyc;
      in_data[k]  = {s2, s1, plain ^ s1 ^ s2};
      in_valid[k] = 1'b1;
`ifdef PRINCE_SBOX_CTRL_INV_EN
      in_inv[k]   = inv;
`endif
      @(negedge clk);
      in_valid[k] = 1'b0;
      chk("busy_t1", 64'(busy[k]), 64'd1);
      first_v = -1; last_v = -1; cnt_v = 0; done = 1'b0; lat = -1; snap = '0;
      for (int n = 0; n < 60 && !done; n++) begin
         rel = cyc - t0;
         if (sbox_in_valid[k]) begin
            if (first_v < 0) first_v = rel;
            last_v = rel;
            cnt_v++;
            tmp = plain >> (4 * (rel - 1));
            chk("feed_nibble", 64'(comb4(sbox_in[k])), 64'(tmp[3:0]));
         end else begin
            chk("sbox_in_zero", 64'(sbox_in[k]), 64'd0);
         end
`ifdef PRINCE_SBOX_CTRL_INV_EN
         chk("sbox_inv_job", 64'(sbox_inv[k]), 64'(inv));
`endif
         if (out_valid[k]) begin
            done = 1'b1;
            lat  = rel;
            snap = out_data[k];
         end else begin
            @(negedge clk);
         end
      end
      chk("out_valid_timeout", 64'(done), 64'd1);
      chk("out_valid_cycle", 64'(lat), 64'(17 + L));
      chk("feed_first", 64'(first_v), 64'd1);
      chk("feed_last", 64'(last_v), 64'd16);
      chk("feed_count", 64'(cnt_v), 64'd16);
      res = comb64(snap);
      for (int h = 0; h < hold; h++) begin
         in_valid[k] = 1'b1;
         in_data[k]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid[k]), 64'd1);
         chk("bp_data", comb64(out_data[k]), comb64(snap));
         chk("bp_in_ready", 64'(in_ready[k]), 64'd0);
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
      chk("idle_in_ready", 64'(in_ready[k]), 64'd1);
      chk("idle_out_valid", 64'(out_valid[k]), 64'd0);
`ifdef PRINCE_SBOX_CTRL_INV_EN
      chk("idle_sbox_inv", 64'(sbox_inv[k]), 64'd0);
`endif
      $display("job inst=%0d lat=%0d inv=%0d plain=%h result=%h t0=%0d", k, lat, inv, plain, res, t0);
   endtask

   typedef struct {
      logic [63:0] plain;
      logic        inv;
      logic [63:0] expd;
   } vec_t;

   initial begin
      vec_t        vecs[$];
      logic [63:0] res, p, s1, s2;
      logic        inv;
      int          t0, ta, tb, g;
      bit          seen;

      vecs.push_back('{64'hFEDCBA9876543210, 1'b0, 64'h4D5E087619CA23FB});
      vecs.push_back('{64'h0000000000000000, 1'b0, 64'hBBBBBBBBBBBBBBBB});
      vecs.push_back('{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h4444444444444444});
      vecs.push_back('{64'h0123456789ABCDEF, 1'b0, 64'hBF32AC916780E5D4});
`ifdef PRINCE_SBOX_CTRL_INV_EN
      vecs.push_back('{64'h4D5E087619CA23FB, 1'b1, 64'hFEDCBA9876543210});
`endif

      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0;
`ifdef PRINCE_SBOX_CTRL_INV_EN
         in_inv[k] = 1'b0;
`endif
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) chk_reset_outputs(k, "reset");
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_job(0, vecs[i].plain, vecs[i].inv, 0, res, t0);
         chk("vector_result", res, vecs[i].expd);
      end

      for (int r = 0; r < 6; r++) begin
         p = {$urandom, $urandom};
`ifdef PRINCE_SBOX_CTRL_INV_EN
         inv = 1'($urandom);
`else
         inv = 1'b0;
`endif
         run_job(0, p, inv, 0, res, t0);
         chk("random_result", res, ref_sub(p, inv));
      end

      run_job(0, 64'hFEDCBA9876543210, 1'b0, 10, res, t0);
      chk("backpressure_result", res, 64'h4D5E087619CA23FB);

      // Abort a job at T8 with reset.
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      t0 = cyc;
      in_data[0]  = {s2, s1, 64'h0123456789ABCDEF ^ s1 ^ s2};
      in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      g = 0;
      while (cyc < t0 + 8 && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("abort_busy_t8", 64'(busy[0]), 64'd1);
      rst = 1'b1;
      #1;
      chk_reset_outputs(0, "abort");
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (out_valid[0]) seen = 1'b1;
      end
      chk("abort_no_out_valid", 64'(seen), 64'd0);
      chk("abort_in_ready", 64'(in_ready[0]), 64'd1);
      run_job(0, 64'hFEDCBA9876543210, 1'b0, 0, res, t0);
      chk("after_abort_result", res, 64'h4D5E087619CA23FB);

      for (int k = 0; k < NI; k++) begin
         run_job(k, 64'hFEDCBA9876543210, 1'b0, 0, res, ta);
         chk("sweep_result_a", res, 64'h4D5E087619CA23FB);
         run_job(k, 64'h0123456789ABCDEF, 1'b0, 0, res, tb);
         chk("sweep_result_b", res, 64'hBF32AC916780E5D4);
         chk("b2b_period", 64'(tb - ta), 64'(18 + lat_of(k)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
